band_seq_ctrl: RTL

//  Sequencer for the equalizer band FIR filters (ROM-coefficient, MAC-accumulate style).
//  Per new audio sample, drives 'sequencing' high for exactly NUM_TAPS cycles, then waits out the
//  ROM/MAC pipeline and issues a one-cycle capture strobe so downstream regs latch lft/rght_out.

---
 rtl/band_seq_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/band_seq_ctrl.sv
// Tap sequencer shared by the equalizer band FIR filters: one sequencing burst per
// accepted sample, a pipeline drain, then a single capture strobe.
module band_seq_ctrl #(
    parameter int NUM_TAPS = 1021,
    parameter int PIPE_DLY = 1,
    parameter int CNT_W    = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic smpl_vld,
    input  logic q_full,
    input  logic clr_ovr,
    output logic sequencing,
    output logic cap,
    output logic busy,
    output logic overrun
);

    localparam int DLY_W = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;
    localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(NUM_TAPS - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(PIPE_DLY - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEQ,
        DRAIN,
        CAP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   tap_cnt;
    logic [CNT_W-1:0]   tap_nxt;
    logic [DLY_W-1:0]   dly_cnt;
    logic [DLY_W-1:0]   dly_nxt;
    logic               ovr_evt;

    always_comb begin
        state_nxt = state;
        tap_nxt   = tap_cnt;
        dly_nxt   = dly_cnt;
        ovr_evt   = smpl_vld && (state != IDLE);

        case (state)
            IDLE: begin
                if (smpl_vld && q_full) begin
                    state_nxt = SEQ;
                    tap_nxt   = '0;
                end
            end
            SEQ: begin
                if (tap_cnt == TAP_LAST) begin
                    state_nxt = (PIPE_DLY == 0) ? CAP : DRAIN;
                    dly_nxt   = '0;
                end else if (tap_cnt > TAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    tap_nxt = tap_cnt + 1'b1;
                end
            end
            DRAIN: begin
                // With no pipeline delay DRAIN is never entered; treat a stray visit as done.
                if ((PIPE_DLY == 0) || (dly_cnt == DLY_LAST)) begin
                    state_nxt = CAP;
                end else if (dly_cnt > DLY_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    dly_nxt = dly_cnt + 1'b1;
                end
            end
            CAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tap_cnt    <= '0;
            dly_cnt    <= '0;
            sequencing <= 1'b0;
            cap        <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tap_cnt    <= tap_nxt;
            dly_cnt    <= dly_nxt;
            sequencing <= (state_nxt == SEQ);
            cap        <= (state_nxt == CAP);
            busy       <= (state_nxt != IDLE);
            if (ovr_evt) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
